// File: rtl/led_chaser_if.sv
// Control/status bundle for led_chaser: En/Restart/Mode in, LED_Out/Step_Pulse out.
// master = driver of controls (board logic or bench), slave = led_chaser.
interface led_chaser_if #(
  parameter int LED_W = 8
);
  logic             En;
  logic             Restart;
  logic [1:0]       Mode;
  logic [LED_W-1:0] LED_Out;
  logic             Step_Pulse;

  modport master (
    output En, Restart, Mode,
    input  LED_Out, Step_Pulse
  );

  modport slave (
    input  En, Restart, Mode,
    output LED_Out, Step_Pulse
  );
endinterface

// File: rtl/led_chaser.sv
// Running-light generator: prescaler -> ms counter -> pattern step (left/right/bounce/fill).
// Ports: CLK, RSTn (async low), io (slave: En, Restart, Mode, LED_Out, Step_Pulse).
// Build option LED_CHASER_ACTIVE_LOW_EN inverts LED_Out for active-low boards.
module led_chaser #(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 50_000,
  parameter int STEP_MS  = 100
) (
  input logic        CLK,
  input logic        RSTn,
  led_chaser_if.slave io
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MMAX = MW'(STEP_MS - 1);
  localparam logic [LED_W-1:0] LSB = LED_W'(1);
  localparam logic [LED_W-1:0] MSB = {1'b1, {(LED_W-1){1'b0}}};

  typedef enum logic [1:0] {
    M_LEFT   = 2'b00,
    M_RIGHT  = 2'b01,
    M_BOUNCE = 2'b10,
    M_FILL   = 2'b11
  } mode_e;

  function automatic logic [LED_W-1:0] seed(input mode_e m);
    logic [LED_W-1:0] s;
    s = LSB;
    unique case (m)
      M_LEFT:   s = LSB;
      M_RIGHT:  s = MSB;
      M_BOUNCE: s = LSB;
      M_FILL:   s = '0;
      default:  s = LSB;
    endcase
    return s;
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic [MW-1:0]    ms_q, ms_d;
  logic [LED_W-1:0] pat_q, pat_d;
  mode_e            mode_q, mode_d;
  logic             up_q, up_d;
  logic             pulse_q, pulse_d;

  logic  tick, step, onehot;
  mode_e mode_in;

  assign mode_in = mode_e'(io.Mode);
  assign tick    = io.En && (presc_q == PMAX);
  assign step    = tick && (ms_q == MMAX);
  assign onehot  = (pat_q != '0) && ((pat_q & (pat_q - LSB)) == '0);

  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    up_d    = up_q;
    pulse_d = 1'b0;
    if (io.Restart) begin
      presc_d = '0;
      ms_d    = '0;
      pat_d   = seed(mode_in);
      mode_d  = mode_in;
      up_d    = 1'b1;
    end else if (io.En) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick)
        ms_d = (ms_q == MMAX) ? '0 : ms_q + MW'(1);
      if (step) begin
        pulse_d = 1'b1;
        if (mode_in != mode_q) begin
          // new mode starts from its seed, not from the old pattern
          pat_d  = seed(mode_in);
          mode_d = mode_in;
          up_d   = 1'b1;
        end else begin
          unique case (mode_q)
            M_LEFT:  pat_d = onehot ? pat_q << 1 : LSB;
            M_RIGHT: pat_d = onehot ? pat_q >> 1 : MSB;
            M_BOUNCE: begin
              unique case (1'b1)
                !onehot: begin
                  pat_d = LSB;
                  up_d  = 1'b1;
                end
                up_q && pat_q[LED_W-1]: begin
                  pat_d = pat_q >> 1;
                  up_d  = 1'b0;
                end
                !up_q && pat_q[0]: begin
                  pat_d = pat_q << 1;
                  up_d  = 1'b1;
                end
                default: pat_d = up_q ? pat_q << 1 : pat_q >> 1;
              endcase
            end
            M_FILL: pat_d = (&pat_q) ? '0 : {pat_q[LED_W-2:0], 1'b1};
            default: pat_d = LSB;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc_q <= '0;
      ms_q    <= '0;
      pat_q   <= LSB;
      mode_q  <= M_LEFT;
      up_q    <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      up_q    <= up_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef LED_CHASER_ACTIVE_LOW_EN
  assign io.LED_Out = ~pat_q;
`else
  assign io.LED_Out = pat_q;
`endif
  assign io.Step_Pulse = pulse_q;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser (LED_W=4, TICK_DIV=4, STEP_MS=3): directed stimulus,
// expected step values/times queued, monitor pops on each Step_Pulse.
module tb_led_chaser;

  logic CLK;
  logic RSTn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0] led;
    int         at;
  } exp_t;
  exp_t sb[$];

  led_chaser_if #(.LED_W(4)) io ();

  led_chaser #(
    .LED_W(4),
    .TICK_DIV(4),
    .STEP_MS(3)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .io(io)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [3:0] ex(input logic [3:0] p);
`ifdef LED_CHASER_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", n, got, want, cyc);
    end
  endtask

  task automatic push(input logic [3:0] p, input int at);
    exp_t e;
    e.led = ex(p);
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // monitor: every Step_Pulse must match the next queued step
  always @(negedge CLK) begin
    if (RSTn && io.Step_Pulse) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("step_led", int'(io.LED_Out), int'(e.led));
        chk("step_time", cyc, e.at);
      end
    end
  end

  int c0, p, c2, c3;
  logic [3:0] bnc [8];
  logic [3:0] fil [6];

  initial begin
    bnc = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0100, 4'b0010, 4'b0001, 4'b0010};
    fil = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
            4'b0000, 4'b0001};
    RSTn       = 1'b0;
    io.En      = 1'b1;
    io.Mode    = 2'b00;
    io.Restart = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_led", int'(io.LED_Out), int'(ex(4'b0001)));
    chk("rst_pulse", int'(io.Step_Pulse), 0);
    RSTn = 1'b1;
    c0 = cyc;
    push(4'b0010, c0 + 12);
    push(4'b0100, c0 + 24);
    push(4'b1000, c0 + 36);
    push(4'b0000, c0 + 48);
    push(4'b0001, c0 + 60);
    push(4'b0010, c0 + 72);
    wait_to(c0 + 75);
    io.Mode = 2'b01;
    wait_to(c0 + 80);
    chk("mode_hold", int'(io.LED_Out), int'(ex(4'b0010)));
    push(4'b1000, c0 + 84);
    push(4'b0100, c0 + 96);
    wait_to(c0 + 107);
    io.Restart = 1'b1;
    wait_to(c0 + 108);
    io.Restart = 1'b0;
    chk("restart_led", int'(io.LED_Out), int'(ex(4'b1000)));
    chk("restart_pulse", int'(io.Step_Pulse), 0);
    p = c0 + 120;
    push(4'b0100, p);
    wait_to(p + 6);
    io.En = 1'b0;
    wait_to(p + 30);
    chk("pause_led", int'(io.LED_Out), int'(ex(4'b0100)));
    chk("pause_pulse", int'(io.Step_Pulse), 0);
    wait_to(p + 56);
    io.En = 1'b1;
    push(4'b0010, p + 62);
    push(4'b0001, p + 74);
    push(4'b0000, p + 86);
    wait_to(p + 88);
    chk("drain1", sb.size(), 0);
    io.Mode = 2'b10;
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    chk("async_rst_led", int'(io.LED_Out), int'(ex(4'b0001)));
    chk("async_rst_pulse", int'(io.Step_Pulse), 0);
    sb.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    c2 = cyc;
    for (int i = 0; i < 8; i++) push(bnc[i], c2 + 12 * (i + 1));
    wait_to(c2 + 97);
    io.Mode    = 2'b11;
    io.Restart = 1'b1;
    wait_to(c2 + 98);
    io.Restart = 1'b0;
    c3 = c2 + 98;
    chk("fill_seed", int'(io.LED_Out), int'(ex(4'b0000)));
    for (int i = 0; i < 6; i++) push(fil[i], c3 + 12 * (i + 1));
    wait_to(c3 + 80);
    chk("drain2", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
